// File: rtl/ddr4_sim_mem_model.sv
// Behavioural DDR4-style channel model: SDR, one data beat per mem_ck rising edge.
// Define PARITY_CHECK_EN to enable command parity checking and the mem_alert_n pulse.
module ddr4_sim_mem_model #(
    parameter int unsigned DQ_W  = 8,
    parameter int unsigned A_W   = 17,
    parameter int unsigned ROW_W = 4,
    parameter int unsigned COL_W = 7,
    parameter int unsigned CL    = 4,
    parameter int unsigned CWL   = 3,
    parameter int unsigned BL    = 8
) (
    input  logic            mem_ck,
    input  logic            mem_reset,
    input  logic            mem_cke,
    input  logic            mem_cs_n,
    input  logic            mem_act_n,
    input  logic [A_W-1:0]  mem_a,
    input  logic            mem_bg,
    input  logic [1:0]      mem_ba,
    input  logic            mem_par,
    input  logic            mem_odt,
    output logic            mem_alert_n,
    inout  wire  [DQ_W-1:0] mem_dq,
    inout  wire             mem_dqs,
    inout  wire             mem_dqs_n,
    inout  wire             mem_dbi_n,
    output logic            cmd_err
);

    localparam int unsigned BEAT_W = $clog2(BL);
    localparam int unsigned ADDR_W = 3 + ROW_W + COL_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = $clog2(CL + CWL + BL) + 1;

    localparam logic [CNT_W-1:0] RD_FIRST = CNT_W'(CL);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(CL + BL - 1);
    localparam logic [CNT_W-1:0] WR_FIRST = CNT_W'(CWL);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(CWL + BL - 1);

    typedef enum logic [2:0] {CmdNop, CmdAct, CmdRd, CmdWr, CmdPre, CmdRef, CmdMrs} cmd_e;

    logic [DQ_W-1:0] mem_array [DEPTH];

    logic [7:0]            bank_open_q, bank_open_d;
    logic [7:0][ROW_W-1:0] bank_row_q, bank_row_d;
    logic                  busy_q, busy_d;
    logic                  is_wr_q, is_wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bst_bank_q, bst_bank_d;
    logic [ROW_W-1:0]      bst_row_q, bst_row_d;
    logic [COL_W-BEAT_W-1:0] bst_col_q, bst_col_d;
    logic                  cmd_err_q, cmd_err_d;

    logic             cmd_valid;
    logic             par_err;
    logic [2:0]       bank;
    cmd_e             cmd;
    logic             err_set;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] beat_off;
    logic [ADDR_W-1:0] burst_addr;
    logic             rd_drive;
    logic             wr_en;
    logic [DQ_W-1:0]  rd_data;
    logic [DQ_W-1:0]  wr_data;
    logic             unused_ok;

    assign cmd_valid = !mem_cs_n && mem_cke;
    assign bank      = {mem_bg, mem_ba};

`ifdef PARITY_CHECK_EN
    logic [2:0] alert_cnt_q;

    assign par_err = cmd_valid && (mem_par != ^{mem_act_n, mem_bg, mem_ba, mem_a});

    // A new error while the alert is active restarts the 4-cycle window.
    always_ff @(posedge mem_ck or posedge mem_reset) begin
        if (mem_reset) begin
            alert_cnt_q <= 3'd0;
        end else if (par_err) begin
            alert_cnt_q <= 3'd4;
        end else if (alert_cnt_q != 3'd0) begin
            alert_cnt_q <= alert_cnt_q - 3'd1;
        end
    end

    assign mem_alert_n = (alert_cnt_q == 3'd0);
`else
    assign par_err     = 1'b0;
    assign mem_alert_n = 1'b1;
`endif

    always_comb begin
        cmd = CmdNop;
        if (cmd_valid && !par_err) begin
            if (!mem_act_n) begin
                cmd = CmdAct;
            end else begin
                case (mem_a[16:14])
                    3'b101:  cmd = CmdRd;
                    3'b100:  cmd = CmdWr;
                    3'b010:  cmd = CmdPre;
                    3'b001:  cmd = CmdRef;
                    3'b000:  cmd = CmdMrs;
                    default: cmd = CmdNop;
                endcase
            end
        end
    end

    assign last_cnt = is_wr_q ? WR_LAST : RD_LAST;

    always_comb begin
        bank_open_d = bank_open_q;
        bank_row_d  = bank_row_q;
        busy_d      = busy_q;
        is_wr_d     = is_wr_q;
        cnt_d       = cnt_q;
        bst_bank_d  = bst_bank_q;
        bst_row_d   = bst_row_q;
        bst_col_d   = bst_col_q;
        err_set     = 1'b0;

        // cnt_q equals the cycle number since the command; the window ends on its last beat.
        if (busy_q) begin
            if (cnt_q == last_cnt) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (cmd)
            CmdAct: begin
                if (bank_open_q[bank]) begin
                    err_set = 1'b1;
                end else begin
                    bank_open_d[bank] = 1'b1;
                    bank_row_d[bank]  = mem_a[ROW_W-1:0];
                end
            end
            CmdRd, CmdWr: begin
                if (!bank_open_q[bank] || busy_q) begin
                    err_set = 1'b1;
                end else begin
                    busy_d     = 1'b1;
                    is_wr_d    = (cmd == CmdWr);
                    cnt_d      = CNT_W'(1);
                    bst_bank_d = bank;
                    bst_row_d  = bank_row_q[bank];
                    bst_col_d  = mem_a[COL_W-1:BEAT_W];
                end
            end
            CmdPre: begin
                if (mem_a[10]) begin
                    bank_open_d = '0;
                end else begin
                    bank_open_d[bank] = 1'b0;
                end
            end
            CmdRef: begin
                if (|bank_open_q) begin
                    err_set = 1'b1;
                end
            end
            default: ;
        endcase

        cmd_err_d = cmd_err_q | err_set | par_err;
    end

    always_ff @(posedge mem_ck or posedge mem_reset) begin
        if (mem_reset) begin
            bank_open_q <= '0;
            bank_row_q  <= '0;
            busy_q      <= 1'b0;
            is_wr_q     <= 1'b0;
            cnt_q       <= '0;
            bst_bank_q  <= '0;
            bst_row_q   <= '0;
            bst_col_q   <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            bank_open_q <= bank_open_d;
            bank_row_q  <= bank_row_d;
            busy_q      <= busy_d;
            is_wr_q     <= is_wr_d;
            cnt_q       <= cnt_d;
            bst_bank_q  <= bst_bank_d;
            bst_row_q   <= bst_row_d;
            bst_col_q   <= bst_col_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign beat_off   = cnt_q - (is_wr_q ? WR_FIRST : RD_FIRST);
    assign burst_addr = {bst_bank_q, bst_row_q, bst_col_q, beat_off[BEAT_W-1:0]};
    assign rd_drive   = busy_q && !is_wr_q && (cnt_q >= RD_FIRST);
    assign wr_en      = busy_q && is_wr_q && (cnt_q >= WR_FIRST);
    assign wr_data    = (mem_dbi_n == 1'b0) ? ~mem_dq : mem_dq;
    assign rd_data    = mem_array[burst_addr];

    // Array has no reset so contents survive mem_reset.
    always_ff @(posedge mem_ck) begin
        if (wr_en) begin
            mem_array[burst_addr] <= wr_data;
        end
    end

    assign mem_dq    = rd_drive ? rd_data : {DQ_W{1'bz}};
    assign mem_dqs   = rd_drive ? beat_off[0] : 1'bz;
    assign mem_dqs_n = rd_drive ? ~beat_off[0] : 1'bz;
    assign mem_dbi_n = rd_drive ? 1'b1 : 1'bz;

    assign cmd_err = cmd_err_q;

    assign unused_ok = ^{mem_odt, mem_par, mem_a, beat_off};

endmodule

// File: tb/tb_ddr4_sim_mem_model.sv
// Self-checking bench for ddr4_sim_mem_model: directed command sequence with random data,
// checked cycle by cycle against an absolute-cycle scheduling model of the memory.
module tb_ddr4_sim_mem_model;

    localparam int CL   = 4;
    localparam int CWL  = 3;
    localparam int BL   = 8;
    localparam int NCYC = 8192;

    logic clk = 1'b0, rst = 1'b1, cke = 1'b1, cs_n = 1'b1, act_n = 1'b1;
    logic bg = 1'b0, par = 1'b0, odt = 1'b0;
    logic [1:0]  ba = 2'd0;
    logic [16:0] a = '1;
    wire  [7:0]  dq;
    wire         dqs, dqs_n, dbi_n;
    logic        alert_n, cmd_err;
    logic [7:0]  tb_dq = 8'd0;
    logic        tb_dbi = 1'b1, tb_en = 1'b0;
    bit          flipv = 1'b0;

    int vectors = 0, miscompares = 0, cyc = 0;

    // Reference model state
    logic [7:0] mm [16384];
    bit         open_m [8];
    int         row_m [8];
    bit         err = 1'b0;
    int         busy_last = -1;
    int         alert_until = -1;
    bit         exp_drv [NCYC];
    logic [7:0] exp_dq [NCYC];
    bit         exp_b0 [NCYC];
    bit         ws_v [NCYC];
    logic [7:0] ws_d [NCYC];
    bit         ws_dbi [NCYC];
    int         ws_a [NCYC];
    logic [7:0] wbuf [8];
    bit         wdbi [8];

    assign dq    = tb_en ? tb_dq : 8'bz;
    assign dbi_n = tb_en ? tb_dbi : 1'bz;
    pulldown pd_dqs (dqs);
    pulldown pd_dqs_n (dqs_n);
    pulldown pd_dbi (dbi_n);

    ddr4_sim_mem_model dut (
        .mem_ck      (clk),
        .mem_reset   (rst),
        .mem_cke     (cke),
        .mem_cs_n    (cs_n),
        .mem_act_n   (act_n),
        .mem_a       (a),
        .mem_bg      (bg),
        .mem_ba      (ba),
        .mem_par     (par),
        .mem_odt     (odt),
        .mem_alert_n (alert_n),
        .mem_dq      (dq),
        .mem_dqs     (dqs),
        .mem_dqs_n   (dqs_n),
        .mem_dbi_n   (dbi_n),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
    endtask

    // Outputs observed just after edge cyc belong to cycle cyc+1.
    task automatic check_bus();
        int m = cyc + 1;
        if (exp_drv[m]) begin
            chk("rd_dq", dq, exp_dq[m]);
            chk("rd_dqs", {7'd0, dqs}, {7'd0, exp_b0[m]});
            chk("rd_dqs_n", {7'd0, dqs_n}, {7'd0, ~exp_b0[m]});
            chk("rd_dbi_n", {7'd0, dbi_n}, 8'd1);
        end else begin
            chk("idle_dqs", {7'd0, dqs}, 8'd0);
            chk("idle_dqs_n", {7'd0, dqs_n}, 8'd0);
            if (!tb_en) chk("idle_dbi_n", {7'd0, dbi_n}, 8'd0);
        end
        chk("cmd_err", {7'd0, cmd_err}, {7'd0, err});
        chk("alert_n", {7'd0, alert_n}, (m <= alert_until) ? 8'd0 : 8'd1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) open_m[i] = 1'b0;
        err = 1'b0;
        busy_last = -1;
        alert_until = -1;
        for (int i = cyc + 1; i < NCYC; i++) begin
            exp_drv[i] = 1'b0;
            ws_v[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int n);
        int bk, base;
        if (ws_v[n]) mm[ws_a[n]] = ws_dbi[n] ? ws_d[n] : ~ws_d[n];
        if (cs_n || !cke) return;
        bk = int'({bg, ba});
`ifdef PARITY_CHECK_EN
        if (par != ^{act_n, bg, ba, a}) begin
            err = 1'b1;
            alert_until = n + 4;
            return;
        end
`endif
        if (!act_n) begin
            if (open_m[bk]) err = 1'b1;
            else begin
                open_m[bk] = 1'b1;
                row_m[bk] = int'(a[3:0]);
            end
            return;
        end
        case (a[16:14])
            3'b101, 3'b100: begin
                if (!open_m[bk] || n <= busy_last) err = 1'b1;
                else begin
                    base = bk * 2048 + row_m[bk] * 128 + int'(a[6:0] & 7'h78);
                    if (a[14] == 1'b1) begin
                        busy_last = n + CL + BL - 1;
                        for (int b = 0; b < BL; b++) begin
                            exp_drv[n + CL + b] = 1'b1;
                            exp_dq[n + CL + b] = mm[base + b];
                            exp_b0[n + CL + b] = (b % 2) == 1;
                        end
                    end else begin
                        busy_last = n + CWL + BL - 1;
                        for (int b = 0; b < BL; b++) begin
                            ws_v[n + CWL + b] = 1'b1;
                            ws_d[n + CWL + b] = wbuf[b];
                            ws_dbi[n + CWL + b] = wdbi[b];
                            ws_a[n + CWL + b] = base + b;
                        end
                    end
                end
            end
            3'b010: begin
                if (a[10]) for (int i = 0; i < 8; i++) open_m[i] = 1'b0;
                else open_m[bk] = 1'b0;
            end
            3'b001: for (int i = 0; i < 8; i++) if (open_m[i]) err = 1'b1;
            default: ;
        endcase
    endtask

    // Entered and left at a falling edge; drives this cycle's inputs and checks after the edge.
    task automatic tick();
        int n = cyc + 1;
        if (n > NCYC - 32) begin
            $display("FAIL cycle_budget cyc=%0d observed=over expected=under", cyc);
            $fatal(1, "cycle budget exhausted");
        end
        par = ^{act_n, bg, ba, a} ^ flipv;
        tb_en = ws_v[n];
        tb_dq = ws_d[n];
        tb_dbi = ws_dbi[n];
        @(posedge clk);
        cyc = n;
        model_edge(n);
        #1;
        check_bus();
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic issue(input logic an, input logic [16:0] av, input int bk, input bit flip);
        cs_n = 1'b0;
        act_n = an;
        a = av;
        {bg, ba} = 3'(bk);
        flipv = flip;
        tick();
        cs_n = 1'b1;
        act_n = 1'b1;
        a = '1;
        flipv = 1'b0;
    endtask

    task automatic act(input int bk, input int row);
        issue(1'b0, 17'(row), bk, 1'b0);
    endtask
    task automatic rd(input int bk, input int col);
        issue(1'b1, {3'b101, 7'd0, 7'(col)}, bk, 1'b0);
    endtask
    task automatic wr(input int bk, input int col);
        issue(1'b1, {3'b100, 7'd0, 7'(col)}, bk, 1'b0);
    endtask
    task automatic pre(input int bk, input bit all);
        issue(1'b1, {3'b010, 3'd0, all, 10'd0}, bk, 1'b0);
    endtask
    task automatic refresh();
        issue(1'b1, {3'b001, 14'd0}, 0, 1'b0);
    endtask

    task automatic rand_wbuf();
        for (int b = 0; b < 8; b++) begin
            wbuf[b] = 8'($urandom);
            wdbi[b] = 1'($urandom);
        end
    endtask

    task automatic do_reset(input int edges);
        rst = 1'b1;
        tb_en = 1'b0;
        model_reset();
        #1;
        check_bus();
        repeat (edges) begin
            @(posedge clk);
            cyc++;
            #1;
            check_bus();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mm[i] = 8'd0;
        @(negedge clk);
        do_reset(2);
        idle(2);

        // Basic write/read with ascending data; RD lands on the first legal cycle.
        for (int b = 0; b < 8; b++) begin
            wbuf[b] = 8'(b);
            wdbi[b] = 1'b1;
        end
        act(0, 3);
        idle(1);
        wr(0, 'h10);
        idle(10);
        rd(0, 'h10);
        idle(12);

        // Data bus inversion on write
        rand_wbuf();
        wbuf[2] = 8'h5A;
        wdbi[2] = 1'b0;
        wr(0, 'h20);
        idle(11);
        rd(0, 'h20);
        idle(12);

        // Random banks, rows, columns and data
        for (int t = 0; t < 10; t++) begin
            int bk = int'($urandom_range(7));
            int row = int'($urandom_range(15));
            int col = int'($urandom_range(127));
            pre(bk, 1'b0);
            act(bk, row);
            rand_wbuf();
            wr(bk, col);
            idle(10 + int'($urandom_range(2)));
            rd(bk, col);
            idle(11 + int'($urandom_range(2)));
        end

        // Refresh rules
        pre(0, 1'b1);
        refresh();
        idle(2);
        act(5, 1);
        refresh();
        idle(2);

        // Contents survive reset; RD to a closed bank is dropped
        do_reset(2);
        act(0, 3);
        rd(0, 'h10);
        idle(12);
        rd(6, 0);
        idle(13);

        // RD while a WR window is pending is dropped
        do_reset(2);
        act(1, 2);
        rand_wbuf();
        wr(1, 'h30);
        rd(1, 'h30);
        idle(10);
        rd(1, 'h30);
        idle(12);

        // PRE during write and read bursts; cke low does not stall a burst
        act(2, 9);
        rand_wbuf();
        wr(2, 'h40);
        pre(2, 1'b0);
        idle(9);
        act(2, 9);
        rd(2, 'h40);
        pre(2, 1'b1);
        cke = 1'b0;
        act(6, 1);
        rd(1, 'h30);
        idle(4);
        cke = 1'b1;
        idle(6);

        // Reset mid-write keeps the beats already stored; reset mid-read releases the bus
        act(3, 1);
        rand_wbuf();
        wr(3, 'h50);
        idle(10);
        rand_wbuf();
        wr(3, 'h50);
        idle(5);
        do_reset(2);
        act(3, 1);
        rd(3, 'h50);
        idle(5);
        do_reset(2);
        idle(2);

        // ACT to an open bank is ignored: the original row stays selected
        act(0, 3);
        act(0, 2);
        rd(0, 'h10);
        idle(12);

`ifdef PARITY_CHECK_EN
        do_reset(2);
        issue(1'b0, 17'd5, 4, 1'b1);
        idle(6);
        issue(1'b0, 17'd5, 4, 1'b1);
        idle(2);
        issue(1'b1, '1, 0, 1'b1);
        idle(6);
        rd(4, 0);
        idle(13);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
